// File: rtl/usb_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// usb_transmitter_pkg
// Shared types and constants for the low-speed USB transmit path.
//   d_port_t        : line state {D-,D+}
//   D_J / D_K / D_SE0 line-state constants
//   USB_SYNC        : SYNC pattern, sent LSB first
//   LS_CLKS_PER_BIT : clk_sys cycles per low-speed bit time at 24 MHz
//   tx_state_t      : transmit FSM state encoding
// -----------------------------------------------------------------------------
package usb_transmitter_pkg;

   typedef logic [1:0] d_port_t;

   localparam d_port_t D_J   = 2'b10;
   localparam d_port_t D_K   = 2'b01;
   localparam d_port_t D_SE0 = 2'b00;

   localparam logic [7:0] USB_SYNC        = 8'h80;
   localparam int         LS_CLKS_PER_BIT = 16;

   typedef logic [2:0] tx_state_t;

   localparam tx_state_t ST_IDLE  = 3'd0;
   localparam tx_state_t ST_SYNC  = 3'd1;
   localparam tx_state_t ST_DATA  = 3'd2;
   localparam tx_state_t ST_STUFF = 3'd3;
   localparam tx_state_t ST_ABORT = 3'd4;
   localparam tx_state_t ST_EOP   = 3'd5;

endpackage

// File: rtl/usb_tx_nrzi.sv
// -----------------------------------------------------------------------------
// usb_tx_nrzi
// Line encoder: NRZI line register, consecutive-ones counter and stuff request.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset (line returns to J)
//   bit_stb_i      : present a new bit on the line at this edge
//   bit_i          : logical bit value (0 toggles, 1 holds)
//   stuff_en_i     : count ones and insert a stuff bit when due
//   se0_i          : drive SE0 instead of a data bit
//   force_j_i      : drive J and clear the ones counter
//   stuff_req_o    : six ones sent; the next strobe must be a stuff bit
//   line_o         : registered line state {D-,D+}
// -----------------------------------------------------------------------------
module usb_tx_nrzi
   import usb_transmitter_pkg::*;
(
   input  logic    clk_i,
   input  logic    reset_i,
   input  logic    bit_stb_i,
   input  logic    bit_i,
   input  logic    stuff_en_i,
   input  logic    se0_i,
   input  logic    force_j_i,
   output logic    stuff_req_o,
   output d_port_t line_o
);

   logic [2:0] ones_q, ones_d;
   d_port_t    line_q, line_d;
   d_port_t    line_tgl;

   assign line_tgl    = (line_q == D_K) ? D_J : D_K;
   assign stuff_req_o = (ones_q == 3'd6);
   assign line_o      = line_q;

   always_comb begin
      line_d = line_q;
      ones_d = ones_q;
      if (bit_stb_i) begin
         if (force_j_i) begin
            line_d = D_J;
            ones_d = '0;
         end else if (se0_i) begin
            line_d = D_SE0;
         end else if (stuff_en_i && stuff_req_o) begin
            // stuff bit is a 0: toggle and restart the run
            line_d = line_tgl;
            ones_d = '0;
         end else if (!bit_i) begin
            line_d = line_tgl;
            ones_d = '0;
         end else if (stuff_en_i) begin
            ones_d = ones_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         line_q <= D_J;
         ones_q <= '0;
      end else begin
         line_q <= line_d;
         ones_q <= ones_d;
      end
   end

endmodule

// File: rtl/usb_transmitter.sv
// -----------------------------------------------------------------------------
// usb_transmitter
// Low-speed USB device transmit engine: SYNC, LSB-first bytes, bit stuffing,
// NRZI and EOP, fed by a valid/ready byte interface.
// Ports:
//   clk, reset          : 24 MHz clock, synchronous active-high reset
//   tx_valid/tx_data/tx_last : byte source; sampled only on an accept edge
//   tx_ready            : accept strobe (IDLE, or last clk of a non-last byte)
//   d_o, d_en           : registered line state and drive enable
//   busy                : packet in progress, including EOP
//   tx_err              : one-cycle pulse on underrun
// Build option USB_TX_UNDERRUN_ABORT_EN: on underrun send eight unstuffed
// ones before EOP; otherwise EOP follows the last complete byte directly.
//
//   state | meaning
//   IDLE  | line J, d_en low, waiting for the first byte
//   SYNC  | sending the 8 SYNC bits
//   DATA  | sending holding-register bits, LSB first
//   STUFF | sending an inserted stuff bit
//   ABORT | eight held bits after an underrun (option build only)
//   EOP   | two bits SE0, one bit J
// -----------------------------------------------------------------------------
module usb_transmitter
   import usb_transmitter_pkg::*;
#(
   parameter int CLKS_PER_BIT = LS_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       tx_ready,
   output d_port_t    d_o,
   output logic       d_en,
   output logic       busy,
   output logic       tx_err
);

   localparam int             TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0]  TMR_LOAD = TW'(CLKS_PER_BIT - 1);

   tx_state_t     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    idx_q, idx_d, idx_inc;
   logic [7:0]    hold_q, hold_d;
   logic          last_q, last_d;
   logic          d_en_q, d_en_d;
   logic          busy_q, busy_d;
   logic          tx_err_q, tx_err_d;

   logic tc, byte_end, stuff_req;
   logic bit_stb, bit_val, stuff_en, se0, force_j;

   assign tc      = (timer_q == '0);
   assign idx_inc = idx_q + 3'd1;
   // a byte ends after bit 7, or after the stuff bit that bit 7 triggered
   assign byte_end = tc && (idx_q == 3'd7) &&
                     (((state_q == ST_DATA) && !stuff_req) || (state_q == ST_STUFF));
   assign tx_ready = (state_q == ST_IDLE) || (byte_end && !last_q);

   always_comb begin
      state_d  = state_q;
      timer_d  = tc ? TMR_LOAD : timer_q - 1'b1;
      idx_d    = idx_q;
      hold_d   = hold_q;
      last_d   = last_q;
      d_en_d   = d_en_q;
      busy_d   = busy_q;
      tx_err_d = 1'b0;
      bit_stb  = 1'b0;
      bit_val  = 1'b0;
      stuff_en = 1'b1;
      se0      = 1'b0;
      force_j  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_d = TMR_LOAD;
            if (tx_valid) begin
               hold_d  = tx_data;
               last_d  = tx_last;
               state_d = ST_SYNC;
               idx_d   = '0;
               bit_stb = 1'b1;
               bit_val = USB_SYNC[0];
               d_en_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_SYNC: begin
            if (tc) begin
               bit_stb = 1'b1;
               if (idx_q == 3'd7) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
                  bit_val = hold_q[0];
               end else begin
                  idx_d   = idx_inc;
                  bit_val = USB_SYNC[idx_inc];
               end
            end
         end
         ST_DATA, ST_STUFF: begin
            if (tc) begin
               bit_stb = 1'b1;
               if ((state_q == ST_DATA) && stuff_req) begin
                  state_d = ST_STUFF;
               end else if (idx_q != 3'd7) begin
                  state_d = ST_DATA;
                  idx_d   = idx_inc;
                  bit_val = hold_q[idx_inc];
               end else if (last_q) begin
                  state_d = ST_EOP;
                  idx_d   = '0;
                  se0     = 1'b1;
               end else if (tx_valid) begin
                  hold_d  = tx_data;
                  last_d  = tx_last;
                  state_d = ST_DATA;
                  idx_d   = '0;
                  bit_val = tx_data[0];
               end else begin
                  tx_err_d = 1'b1;
                  idx_d    = '0;
`ifdef USB_TX_UNDERRUN_ABORT_EN
                  state_d  = ST_ABORT;
                  bit_val  = 1'b1;
                  stuff_en = 1'b0;
`else
                  state_d  = ST_EOP;
                  se0      = 1'b1;
`endif
               end
            end
         end
`ifdef USB_TX_UNDERRUN_ABORT_EN
         ST_ABORT: begin
            // stuffing disabled so the host sees a stuff error
            stuff_en = 1'b0;
            if (tc) begin
               bit_stb = 1'b1;
               if (idx_q == 3'd7) begin
                  state_d = ST_EOP;
                  idx_d   = '0;
                  se0     = 1'b1;
               end else begin
                  idx_d   = idx_inc;
                  bit_val = 1'b1;
               end
            end
         end
`endif
         ST_EOP: begin
            if (tc) begin
               if (idx_q == 3'd2) begin
                  state_d = ST_IDLE;
                  d_en_d  = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  bit_stb = 1'b1;
                  idx_d   = idx_inc;
                  se0     = (idx_q == 3'd0);
                  force_j = (idx_q != 3'd0);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         timer_q  <= TMR_LOAD;
         idx_q    <= '0;
         hold_q   <= '0;
         last_q   <= 1'b0;
         d_en_q   <= 1'b0;
         busy_q   <= 1'b0;
         tx_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         hold_q   <= hold_d;
         last_q   <= last_d;
         d_en_q   <= d_en_d;
         busy_q   <= busy_d;
         tx_err_q <= tx_err_d;
      end
   end

   usb_tx_nrzi u_nrzi (
      .clk_i       (clk),
      .reset_i     (reset),
      .bit_stb_i   (bit_stb),
      .bit_i       (bit_val),
      .stuff_en_i  (stuff_en),
      .se0_i       (se0),
      .force_j_i   (force_j),
      .stuff_req_o (stuff_req),
      .line_o      (d_o)
   );

   assign d_en   = d_en_q;
   assign busy   = busy_q;
   assign tx_err = tx_err_q;

endmodule

// File: tb/tb_usb_transmitter.sv
module tb_usb_transmitter;
   import usb_transmitter_pkg::*;

   logic       clk = 1'b0;
   logic       reset, tx_valid, tx_last;
   logic [7:0] tx_data;
   logic       tx_ready, d_en, busy, tx_err;
   d_port_t    d_o;

   usb_transmitter #(.CLKS_PER_BIT(16)) dut (
      .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_last(tx_last), .tx_ready(tx_ready), .d_o(d_o), .d_en(d_en),
      .busy(busy), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

`ifdef USB_TX_UNDERRUN_ABORT_EN
   localparam int UR_LEN = 432;
`else
   localparam int UR_LEN = 304;
`endif

   typedef struct {
      logic [7:0] b0, b1, b2;
      int n, nprov, len, rdy0, rdy1, err;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] pkt [3];
   int cur_n, cur_nprov, ptr;

   d_port_t cap_sym[$];
   int      cap_rdy[$];
   int      cap_err[$];
   int      cap_busy_bad, cap_idle;

   d_port_t exp_bit[$];
   int      exp_rdy[$];
   int      exp_err[$];
   d_port_t m_lvl;
   int      m_ones;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // reference: logical bitstream -> stuffing -> NRZI, one symbol per bit time
   task automatic model_bit(input logic b);
      if (!b) begin
         m_lvl  = (m_lvl == D_K) ? D_J : D_K;
         m_ones = 0;
      end else begin
         m_ones++;
      end
      exp_bit.push_back(m_lvl);
      if (m_ones == 6) begin
         m_lvl  = (m_lvl == D_K) ? D_J : D_K;
         m_ones = 0;
         exp_bit.push_back(m_lvl);
      end
   endtask

   task automatic build_model(input int n, input int nprov);
      logic [7:0] s, b;
      int end_c;
      s = USB_SYNC;
      exp_bit.delete(); exp_rdy.delete(); exp_err.delete();
      m_lvl  = D_J;
      m_ones = 0;
      for (int i = 0; i < 8; i++) model_bit(s[i]);
      for (int j = 0; j < nprov; j++) begin
         b = pkt[j];
         for (int i = 0; i < 8; i++) model_bit(b[i]);
         end_c = exp_bit.size() * 16 - 1;
         if (j < n - 1) exp_rdy.push_back(end_c);
         if (j == nprov - 1 && nprov < n) exp_err.push_back(end_c + 1);
      end
`ifdef USB_TX_UNDERRUN_ABORT_EN
      if (nprov < n) repeat (8) exp_bit.push_back(m_lvl);
`endif
      exp_bit.push_back(D_SE0);
      exp_bit.push_back(D_SE0);
      exp_bit.push_back(D_J);
   endtask

   task automatic check_packet(input int n, input int nprov, input string name);
      int first;
      first = -1;
      build_model(n, nprov);
      check({name, " len"}, cap_sym.size(), exp_bit.size() * 16);
      for (int c = 0; c < cap_sym.size(); c++)
         if (first < 0 && (c / 16 >= exp_bit.size() || cap_sym[c] != exp_bit[c / 16]))
            first = c;
      n_cmp++;
      if (first >= 0) begin
         n_bad++;
         $display("FAIL %s line: cycle %0d got %b, required %b", name, first,
                  cap_sym[first], (first / 16 < exp_bit.size()) ? exp_bit[first / 16] : 2'b11);
      end
      check({name, " rdy_count"}, cap_rdy.size(), exp_rdy.size());
      for (int i = 0; i < cap_rdy.size() && i < exp_rdy.size(); i++)
         check({name, " rdy_at"}, cap_rdy[i], exp_rdy[i]);
      check({name, " err_count"}, cap_err.size(), exp_err.size());
      for (int i = 0; i < cap_err.size() && i < exp_err.size(); i++)
         check({name, " err_at"}, cap_err[i], exp_err[i]);
      check({name, " busy_vs_den"}, cap_busy_bad, 0);
   endtask

   task automatic drive();
      tx_valid = (ptr < cur_nprov);
      if (tx_valid) begin
         tx_data = pkt[2'(ptr)];
         tx_last = (ptr == cur_n - 1);
      end else begin
         tx_data = 8'($urandom);
         tx_last = 1'($urandom);
      end
      if (tx_valid && tx_ready) ptr++;
   endtask

   // called just after an edge with the DUT idle; returns in the first idle cycle
   task automatic run_packet(input int n, input int nprov, input string name);
      bit started, done;
      int k;
      started = 0; done = 0; k = 0;
      cap_sym.delete(); cap_rdy.delete(); cap_err.delete();
      cap_busy_bad = 0; cap_idle = 0;
      cur_n = n; cur_nprov = nprov; ptr = 0;
      drive();
      for (int c = 0; c < 3000 && !done; c++) begin
         @(posedge clk); #1;
         if (d_en) begin
            started = 1;
            cap_sym.push_back(d_o);
            if (tx_ready) cap_rdy.push_back(k);
            if (tx_err) cap_err.push_back(k);
            if (busy != d_en) cap_busy_bad++;
            k++;
         end else begin
            if (busy) cap_busy_bad++;
            if (started) done = 1;
            else cap_idle++;
         end
         if (!done) drive();
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s timeout: got no packet end in 3000 clks, required end", name);
      end
      check_packet(n, nprov, name);
   endtask

   function automatic string sym_str();
      string s;
      s = "";
      for (int b = 0; b * 16 + 8 < cap_sym.size(); b++)
         case (cap_sym[b * 16 + 8])
            D_J:     s = {s, "J"};
            D_K:     s = {s, "K"};
            D_SE0:   s = {s, "S"};
            default: s = {s, "?"};
         endcase
      return s;
   endfunction

   task automatic check_str(input string name, input string req);
      string act;
      act = sym_str();
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %s, required %s", name, act, req);
      end
   endtask

   vec_t tbl [6];
   int   rn, rnp, rgap;
   int   req_rdy[$];

   initial begin
      tbl[0] = '{8'hA5, 8'h00, 8'h00, 1, 1, 304,  -1,  -1,  -1};
      tbl[1] = '{8'hFF, 8'h00, 8'h00, 1, 1, 320,  -1,  -1,  -1};
      tbl[2] = '{8'h01, 8'h02, 8'h03, 3, 3, 560, 255, 383,  -1};
      tbl[3] = '{8'h55, 8'h66, 8'h00, 2, 1, UR_LEN, 255, -1, 256};
      tbl[4] = '{8'hFC, 8'h00, 8'h00, 2, 2, 448, 271,  -1,  -1};
      tbl[5] = '{8'hFC, 8'h00, 8'h00, 1, 1, 320,  -1,  -1,  -1};

      reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset d_o", int'(d_o), int'(D_J));
      check("reset d_en", int'(d_en), 0);
      check("reset busy", int'(busy), 0);
      check("reset tx_err", int'(tx_err), 0);
      check("reset tx_ready", int'(tx_ready), 1);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         pkt[0] = tbl[i].b0; pkt[1] = tbl[i].b1; pkt[2] = tbl[i].b2;
         run_packet(tbl[i].n, tbl[i].nprov, $sformatf("vec%0d", i));
         check($sformatf("vec%0d const_len", i), cap_sym.size(), tbl[i].len);
         req_rdy.delete();
         if (tbl[i].rdy0 >= 0) req_rdy.push_back(tbl[i].rdy0);
         if (tbl[i].rdy1 >= 0) req_rdy.push_back(tbl[i].rdy1);
         check($sformatf("vec%0d const_rdy_count", i), cap_rdy.size(), req_rdy.size());
         for (int j = 0; j < cap_rdy.size() && j < req_rdy.size(); j++)
            check($sformatf("vec%0d const_rdy_at", i), cap_rdy[j], req_rdy[j]);
         check($sformatf("vec%0d const_err_at", i),
               (cap_err.size() > 0) ? cap_err[0] : -1, tbl[i].err);
      end

      pkt[0] = 8'hA5;
      run_packet(1, 1, "a5");
      check_str("a5 symbols", "KJKJKJKKKJJKJJKKSSJ");
      pkt[0] = 8'hFF;
      run_packet(1, 1, "ff");
      check_str("ff symbols", "KJKJKJKKKKKKKJJJJSSJ");

      // reset in the middle of the data byte
      pkt[0] = 8'hA5;
      tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      check("midrst pre d_en", int'(d_en), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst d_en", int'(d_en), 0);
      check("midrst d_o", int'(d_o), int'(D_J));
      check("midrst busy", int'(busy), 0);
      reset = 1'b0;
      pkt[0] = 8'h3C;
      run_packet(1, 1, "after_rst");

      // back-to-back packets
      pkt[0] = 8'h81;
      run_packet(1, 1, "b2b_first");
      check("b2b gap d_en", int'(d_en), 0);
      check("b2b gap d_o", int'(d_o), int'(D_J));
      pkt[0] = 8'h7E;
      run_packet(1, 1, "b2b_second");
      check("b2b extra idle clks", cap_idle, 0);

      for (int r = 0; r < 12; r++) begin
         rn   = $urandom_range(1, 3);
         rnp  = rn;
         rgap = $urandom_range(0, 4);
         for (int j = 0; j < 3; j++)
            case ($urandom_range(0, 3))
               0:       pkt[j] = 8'hFF;
               1:       pkt[j] = 8'hFC;
               default: pkt[j] = 8'($urandom);
            endcase
         if (rn > 1 && $urandom_range(0, 3) == 0) rnp = $urandom_range(1, rn - 1);
         tx_valid = 1'b0;
         repeat (rgap) begin
            @(posedge clk); #1;
            tx_data = 8'($urandom);
         end
         run_packet(rn, rnp, $sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
